sd_spi_responder: RTL and testbench

SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

---
 rtl/sd_spi_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_sd_spi_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SD card SPI-mode responder (mode 0).
// Init handshake, CMD17 block read and CMD24 block write against a byte store.
module sd_spi_responder #(
   parameter int ACMD41_RETRIES = 2,
   parameter int NCR_BYTES      = 1,
   parameter int NAC_BYTES      = 1,
   parameter int BUSY_BYTES     = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sd_sclk,
   input  logic        sd_cs,
   input  logic        sd_mosi,
   output logic        sd_miso,
   output logic [31:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        card_ready,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index
);

   typedef enum logic [3:0] {
      S_CMD, S_NCR, S_R1, S_RD_GAP, S_RD_TOK, S_RD_DATA,
      S_RD_CRC, S_WR_WAIT, S_WR_DATA, S_WR_CRC, S_WR_RESP, S_WR_BUSY
   } state_t;

   localparam logic [15:0] NCR_LAST  = 16'(NCR_BYTES - 1);
   localparam logic [15:0] NAC_LAST  = 16'(NAC_BYTES - 1);
   localparam logic [15:0] BUSY_LAST = 16'(BUSY_BYTES - 1);
   localparam logic [7:0]  RETRY_MAX = 8'(ACMD41_RETRIES);

   state_t      state, state_nxt;
   logic [2:0]  sclk_q;
   logic [1:0]  cs_q, mosi_q;
   logic        sel, rise, fall, byte_done, load;
   logic [2:0]  bit_cnt;
   logic [6:0]  rx_sr;
   logic [7:0]  rx_byte, tx_sr, tx_byte;
   logic [2:0]  cmd_cnt;
   logic [5:0]  cmd_idx_r;
   logic [31:0] arg, base;
   logic [15:0] cnt;
   logic [7:0]  r1, acmd_cnt;
   logic        app;

   assign sel       = ~cs_q[1];
   assign rise      = sclk_q[1] & ~sclk_q[2];
   assign fall      = ~sclk_q[1] & sclk_q[2];
   assign rx_byte   = {rx_sr, mosi_q[1]};
   assign byte_done = sel & rise & (bit_cnt == 3'd7);
   assign load      = sel & fall & (bit_cnt == 3'd0);
   assign sd_miso   = tx_sr[7];

   // two-flop synchronizers plus one delay flop for sclk edge detect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_q <= 3'b000;
         cs_q   <= 2'b11;
         mosi_q <= 2'b11;
      end else begin
         sclk_q <= {sclk_q[1:0], sd_sclk};
         cs_q   <= {cs_q[0], sd_cs};
         mosi_q <= {mosi_q[0], sd_mosi};
      end
   end

   // bit shifting: sample on rise, shift or reload tx on fall
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt <= 3'd0;
         rx_sr   <= 7'd0;
         tx_sr   <= 8'hFF;
      end else if (!sel) begin
         bit_cnt <= 3'd0;
         tx_sr   <= 8'hFF;
      end else begin
         if (rise) begin
            rx_sr   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (fall) begin
            tx_sr <= (bit_cnt == 3'd0) ? tx_byte : {tx_sr[6:0], 1'b1};
         end
      end
   end

   // state register: advances once per completed byte slot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_CMD;
      end else if (!sel) begin
         state <= S_CMD;
      end else if (byte_done) begin
         state <= state_nxt;
      end
   end

   // next-state: what the following byte slot will be
   always_comb begin
      state_nxt = state;
      case (state)
         S_CMD: begin
            if (cmd_cnt == 3'd5) begin
               state_nxt = (NCR_BYTES == 0) ? S_R1 : S_NCR;
            end
         end
         S_NCR:     if (cnt == NCR_LAST) state_nxt = S_R1;
         S_R1: begin
            if (r1 == 8'h00 && cmd_index == 6'd17) begin
               state_nxt = (NAC_BYTES == 0) ? S_RD_TOK : S_RD_GAP;
            end else if (r1 == 8'h00 && cmd_index == 6'd24) begin
               state_nxt = S_WR_WAIT;
            end else begin
               state_nxt = S_CMD;
            end
         end
         S_RD_GAP:  if (cnt == NAC_LAST) state_nxt = S_RD_TOK;
         S_RD_TOK:  state_nxt = S_RD_DATA;
         S_RD_DATA: if (cnt == 16'd511) state_nxt = S_RD_CRC;
         S_RD_CRC:  if (cnt == 16'd1) state_nxt = S_CMD;
         S_WR_WAIT: if (rx_byte == 8'hFE) state_nxt = S_WR_DATA;
         S_WR_DATA: if (cnt == 16'd511) state_nxt = S_WR_CRC;
         S_WR_CRC:  if (cnt == 16'd1) state_nxt = S_WR_RESP;
         S_WR_RESP: state_nxt = (BUSY_BYTES == 0) ? S_CMD : S_WR_BUSY;
         S_WR_BUSY: if (cnt == BUSY_LAST) state_nxt = S_CMD;
         default:   state_nxt = S_CMD;
      endcase
   end

   // output: byte to present on miso during the current slot
   always_comb begin
      tx_byte = 8'hFF;
      case (state)
         S_R1:      tx_byte = r1;
         S_RD_TOK:  tx_byte = 8'hFE;
         S_RD_DATA: tx_byte = mem_rdata;
         S_WR_RESP: tx_byte = 8'h05;
         S_WR_BUSY: tx_byte = 8'h00;
         default:   tx_byte = 8'hFF;
      endcase
   end

   // command capture, R1 decode, slot counter and store access
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_cnt    <= 3'd0;
         cmd_idx_r  <= 6'd0;
         arg        <= 32'd0;
         base       <= 32'd0;
         cnt        <= 16'd0;
         r1         <= 8'hFF;
         acmd_cnt   <= 8'd0;
         app        <= 1'b0;
         card_ready <= 1'b0;
         cmd_valid  <= 1'b0;
         cmd_index  <= 6'd0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 8'd0;
         mem_we     <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         mem_we    <= 1'b0;
         if (!sel) begin
            cmd_cnt <= 3'd0;
            cnt     <= 16'd0;
         end else begin
            if (load && state == S_RD_DATA) begin
               mem_addr <= mem_addr + 32'd1;
            end
            if (byte_done) begin
               cnt <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
               if (state == S_CMD) begin
                  if (cmd_cnt == 3'd0) begin
                     if (rx_byte[7:6] == 2'b01) begin
                        cmd_cnt   <= 3'd1;
                        cmd_idx_r <= rx_byte[5:0];
                     end
                  end else if (cmd_cnt != 3'd5) begin
                     arg     <= {arg[23:0], rx_byte};
                     cmd_cnt <= cmd_cnt + 3'd1;
                  end else begin
                     cmd_cnt   <= 3'd0;
                     cmd_valid <= 1'b1;
                     cmd_index <= cmd_idx_r;
                     base      <= {arg[31:9], 9'd0};
                     if (cmd_idx_r == 6'd17) begin
                        mem_addr <= {arg[31:9], 9'd0};
                     end
                     app <= 1'b0;
                     unique case (1'b1)
                        (cmd_idx_r == 6'd0): begin
                           r1         <= 8'h01;
                           card_ready <= 1'b0;
                           acmd_cnt   <= 8'd0;
                        end
                        (cmd_idx_r == 6'd55): begin
                           r1  <= card_ready ? 8'h00 : 8'h01;
                           app <= 1'b1;
                        end
                        (cmd_idx_r == 6'd41 && app): begin
                           if (acmd_cnt < RETRY_MAX) begin
                              r1       <= 8'h01;
                              acmd_cnt <= acmd_cnt + 8'd1;
                           end else begin
                              r1         <= 8'h00;
                              card_ready <= 1'b1;
                           end
                        end
                        (cmd_idx_r == 6'd17 || cmd_idx_r == 6'd24): begin
                           r1 <= card_ready ? 8'h00 : 8'h05;
                        end
                        default: begin
                           r1 <= card_ready ? 8'h04 : 8'h05;
                        end
                     endcase
                  end
               end
               if (state == S_WR_DATA) begin
                  mem_we    <= 1'b1;
                  mem_wdata <= rx_byte;
                  mem_addr  <= base + {16'd0, cnt};
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb_sd_spi_responder: directed SPI host sequence with randomized data
// checked against a rule-level card model and a byte-store model.
module tb_sd_spi_responder;

   localparam int RETRIES = 2;
   localparam int NCR     = 1;
   localparam int NAC     = 1;
   localparam int BUSY    = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sd_sclk = 1'b0;
   logic        sd_cs = 1'b1;
   logic        sd_mosi = 1'b1;
   logic        sd_miso;
   logic [31:0] mem_addr;
   logic [7:0]  mem_rdata = 8'd0;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        card_ready;
   logic        cmd_valid;
   logic [5:0]  cmd_index;

   int checks = 0;
   int failures = 0;

   logic [7:0]  store [0:2047];
   logic [7:0]  rd_p = 8'd0;
   logic [31:0] wr_addr_q [$];
   logic [7:0]  wr_data_q [$];
   int          cv_count = 0;
   logic [5:0]  cv_last = 6'd0;

   bit m_ready = 1'b0;
   bit m_app = 1'b0;
   int m_acmd = 0;

   always #5 clk = ~clk;

   sd_spi_responder #(
      .ACMD41_RETRIES(RETRIES),
      .NCR_BYTES(NCR),
      .NAC_BYTES(NAC),
      .BUSY_BYTES(BUSY)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .sd_sclk(sd_sclk),
      .sd_cs(sd_cs),
      .sd_mosi(sd_mosi),
      .sd_miso(sd_miso),
      .mem_addr(mem_addr),
      .mem_rdata(mem_rdata),
      .mem_wdata(mem_wdata),
      .mem_we(mem_we),
      .card_ready(card_ready),
      .cmd_valid(cmd_valid),
      .cmd_index(cmd_index)
   );

   // backing store with two-cycle read latency, plus write and command logs
   always @(posedge clk) begin
      rd_p      <= store[mem_addr[10:0]];
      mem_rdata <= rd_p;
      if (mem_we) begin
         store[mem_addr[10:0]] = mem_wdata;
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end
      if (cmd_valid) begin
         cv_count++;
         cv_last = cmd_index;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      logic [7:0] r;
      r = 8'd0;
      for (int i = 7; i >= 0; i--) begin
         sd_mosi = tx[i];
         #40;
         r = {r[6:0], sd_miso};
         sd_sclk = 1'b1;
         #40;
         sd_sclk = 1'b0;
      end
      rx = r;
   endtask

   task automatic model_r1(input int idx, output logic [7:0] r);
      if (idx == 0) begin
         r = 8'h01;
         m_ready = 1'b0;
         m_acmd = 0;
      end else if (idx == 55) begin
         r = m_ready ? 8'h00 : 8'h01;
      end else if (idx == 41 && m_app) begin
         if (m_acmd < RETRIES) begin
            r = 8'h01;
            m_acmd++;
         end else begin
            r = 8'h00;
            m_ready = 1'b1;
         end
      end else if (idx == 17 || idx == 24) begin
         r = m_ready ? 8'h00 : 8'h05;
      end else begin
         r = m_ready ? 8'h04 : 8'h05;
      end
      m_app = (idx == 55);
   endtask

   task automatic do_cmd(input int idx, input logic [31:0] arg,
                         output logic [7:0] r1);
      logic [7:0] rx;
      logic [7:0] exp_r1;
      int cv0;
      cv0 = cv_count;
      xfer(8'h40 | 8'(idx), rx);
      chk($sformatf("idle_miso_cmd%0d", idx), rx, 8'hFF);
      for (int i = 3; i >= 0; i--) xfer(arg[8*i +: 8], rx);
      xfer(8'h95, rx);
      model_r1(idx, exp_r1);
      for (int i = 0; i < NCR; i++) begin
         xfer(8'hFF, rx);
         chk("ncr_byte", rx, 8'hFF);
      end
      xfer(8'hFF, r1);
      chk($sformatf("r1_cmd%0d", idx), r1, exp_r1);
      chk("cmd_valid_count", cv_count - cv0, 1);
      chk("cmd_index", cv_last, idx);
   endtask

   initial begin
      logic [7:0]  rx;
      logic [7:0]  r1;
      logic [31:0] arg;
      logic [31:0] base;
      logic [7:0]  wdat [0:511];
      int          errs;
      int          n0;

      for (int i = 0; i < 2048; i++) store[i] = 8'($urandom);
      for (int i = 0; i < 512; i++) store[512 + i] = 8'(i);

      #35;
      chk("rst_miso", sd_miso, 1);
      chk("rst_we", mem_we, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_index", cmd_index, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_card_ready", card_ready, 0);
      reset_n = 1'b1;
      #100;
      sd_cs = 1'b0;
      #100;

      do_cmd(17, 32'h0, r1);
      xfer(8'hFF, rx);
      chk("notready_no_token", rx, 8'hFF);

      do_cmd(0, 32'h0, r1);
      chk("cmd0_ready", card_ready, 0);

      for (int k = 0; k < 3; k++) begin
         do_cmd(55, 32'h0, r1);
         do_cmd(41, 32'h4000_0000, r1);
         chk($sformatf("ready_after_acmd41_%0d", k), card_ready, m_ready);
      end
      chk("init_done", card_ready, 1);

      do_cmd(8, 32'h1AA, r1);
      do_cmd(41, 32'h0, r1);

      arg = 32'h200 | 32'($urandom_range(0, 511));
      do_cmd(17, arg, r1);
      base = arg - (arg % 512);
      for (int i = 0; i < NAC; i++) begin
         xfer(8'hFF, rx);
         chk("nac_byte", rx, 8'hFF);
      end
      xfer(8'hFF, rx);
      chk("rd_token", rx, 8'hFE);
      errs = 0;
      for (int i = 0; i < 512; i++) begin
         xfer(8'hFF, rx);
         if (rx !== 8'(base + i)) errs++;
      end
      chk("rd_data_errs", errs, 0);
      xfer(8'hFF, rx);
      chk("rd_crc0", rx, 8'hFF);
      xfer(8'hFF, rx);
      chk("rd_crc1", rx, 8'hFF);
      xfer(8'hFF, rx);
      chk("rd_then_idle", rx, 8'hFF);

      arg = 32'h400 | 32'($urandom_range(0, 511));
      do_cmd(24, arg, r1);
      base = arg - (arg % 512);
      xfer(8'hFF, rx);
      chk("wr_wait_idle", rx, 8'hFF);
      xfer(8'hFE, rx);
      chk("wr_token_slot", rx, 8'hFF);
      n0 = wr_addr_q.size();
      errs = 0;
      for (int i = 0; i < 512; i++) begin
         wdat[i] = 8'($urandom);
         xfer(wdat[i], rx);
         if (rx !== 8'hFF) errs++;
      end
      chk("wr_data_miso_errs", errs, 0);
      xfer(8'($urandom), rx);
      xfer(8'($urandom), rx);
      xfer(8'hFF, rx);
      chk("wr_resp", rx, 8'h05);
      for (int i = 0; i < BUSY; i++) begin
         xfer(8'hFF, rx);
         chk("wr_busy", rx, 8'h00);
      end
      xfer(8'hFF, rx);
      chk("wr_then_idle", rx, 8'hFF);
      #100;
      chk("wr_count", wr_addr_q.size() - n0, 512);
      errs = 0;
      for (int i = 0; i < 512; i++) begin
         if (n0 + i < wr_addr_q.size()) begin
            if (wr_addr_q[n0 + i] !== base + 32'(i)) errs++;
            if (wr_data_q[n0 + i] !== wdat[i]) errs++;
         end
      end
      chk("wr_log_errs", errs, 0);

      arg = 32'hFFFF_FE00 | 32'($urandom_range(0, 511));
      do_cmd(24, arg, r1);
      base = arg - (arg % 512);
      xfer(8'hFE, rx);
      n0 = wr_addr_q.size();
      for (int i = 0; i < 100; i++) begin
         wdat[i] = 8'($urandom);
         xfer(wdat[i], rx);
      end
      #20;
      sd_cs = 1'b1;
      #200;
      chk("cs_high_miso", sd_miso, 1);
      chk("partial_wr_count", wr_addr_q.size() - n0, 100);
      errs = 0;
      for (int i = 0; i < 100; i++) begin
         if (n0 + i < wr_addr_q.size()) begin
            if (wr_addr_q[n0 + i] !== base + 32'(i)) errs++;
            if (wr_data_q[n0 + i] !== wdat[i]) errs++;
         end
      end
      chk("partial_wr_log_errs", errs, 0);
      chk("cs_high_keeps_ready", card_ready, 1);
      sd_cs = 1'b0;
      #100;
      do_cmd(0, 32'h0, r1);
      chk("cmd0_clears_ready", card_ready, 0);
      chk("no_writes_after_cs", wr_addr_q.size() - n0, 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
